// File: rtl/fb_pkg.sv
// Frame buffer constants shared by the write arbiter and the VGA interface.
// Pixel address is {x[9:0], y[8:0]}.
package fb_pkg;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COLOUR_W = 12;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned X_LAST   = 639;
  localparam int unsigned Y_LAST   = 479;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    WAIT_FRAME = 2'd1,
    CLEAR      = 2'd2
  } fb_state_e;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o,
  output logic          any_o
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    gnt_o = '0;
    win_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx[PW-1:0]]) begin
        any_o              = 1'b1;
        gnt_o[idx[PW-1:0]] = 1'b1;
        win_o              = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns the frame buffer write port: round-robin grants to game-logic requesters
// plus a frame-aligned full-screen clear sweep that blocks them while it runs.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned          NUM_REQ      = 3,
  parameter int unsigned          ADDR_W       = fb_pkg::ADDR_W,
  parameter int unsigned          COLOUR_W     = fb_pkg::COLOUR_W,
  parameter int unsigned          X_LAST       = fb_pkg::X_LAST,
  parameter int unsigned          Y_LAST       = fb_pkg::Y_LAST,
  parameter logic [COLOUR_W-1:0]  CLEAR_COLOUR = '0
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*ADDR_W-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*COLOUR_W-1:0]  REQ_COLOUR,
  output logic [NUM_REQ-1:0]           GNT,
  input  logic                         CLEAR_START,
  input  logic                         END_OF_SCREEN,
  output logic                         WR_EN,
  output logic [ADDR_W-1:0]            WR_ADDR,
  output logic [COLOUR_W-1:0]          WR_DATA,
  output logic                         CLEAR_BUSY,
  output logic                         CLEAR_DONE
);

  localparam int unsigned    PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [X_W-1:0] X_END    = X_W'(X_LAST);
  localparam logic [Y_W-1:0] Y_END    = Y_W'(Y_LAST);
  localparam logic [PW-1:0]  PTR_LAST = PW'(NUM_REQ - 1);

  fb_state_e             state_q;
  logic [PW-1:0]         rr_ptr_q;
  logic                  clear_pending_q;
  logic                  sweep_end_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic                  wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [COLOUR_W-1:0]   wr_data_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_W-1:0]     req_addr [NUM_REQ];
  logic [COLOUR_W-1:0]   req_col  [NUM_REQ];
  logic [NUM_REQ-1:0]    win_oh;
  logic [PW-1:0]         win;
  logic                  win_any;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_addr[i] = REQ_ADDR[i*ADDR_W +: ADDR_W];
      req_col[i]  = REQ_COLOUR[i*COLOUR_W +: COLOUR_W];
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (REQ),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_oh),
    .win_o (win),
    .any_o (win_any)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q         <= ARB;
      rr_ptr_q        <= '0;
      clear_pending_q <= 1'b0;
      sweep_end_q     <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      gnt_q           <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      gnt_q   <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ARB: begin
          if (win_any) begin
            gnt_q     <= win_oh;
            wr_en_q   <= 1'b1;
            wr_addr_q <= req_addr[win];
            wr_data_q <= req_col[win];
            rr_ptr_q  <= (win == PTR_LAST) ? '0 : win + 1'b1;
          end
          if (CLEAR_START) begin
            clear_pending_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (END_OF_SCREEN && clear_pending_q) begin
            state_q     <= CLEAR;
            x_q         <= '0;
            y_q         <= '0;
            sweep_end_q <= 1'b0;
          end
        end
        CLEAR: begin
          // sweep_end_q spends one extra cycle in CLEAR so DONE lands after the last write is visible
          if (sweep_end_q) begin
            sweep_end_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            clear_pending_q <= 1'b0;
            state_q         <= ARB;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_W'(fb_addr(x_q, y_q));
            wr_data_q <= CLEAR_COLOUR;
            if (x_q == X_END) begin
              x_q <= '0;
              if (y_q == Y_END) sweep_end_q <= 1'b1;
              else              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign GNT        = gnt_q;
  assign WR_EN      = wr_en_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign CLEAR_BUSY = busy_q;
  assign CLEAR_DONE = done_q;

endmodule
